scan_control_unit: RTL and testbench
====================================

Name: scan_control_unit

Overview:
- Control FSM driving the 8-bit y / 3-bit s data path through its control inputs, and reading back the data path's status bits `b` (= y[s]) and `y_inc` (= s==2).
- Runs a bit-scan accumulate algorithm on each start request:
  - load x into y, clear s;
  - for N_STEPS iterations: if y[s]=1 then y<=y+s; then s<=s+1, and also y<=y+1 when y_inc is set.
- Signals completion with a one-cycle done pulse.
- Sits between the top-level start/done handshake and the data path.

Parameters:
- N_STEPS, 8, number of scan iterations per run (1..2**CNT_W).
- CNT_W, 3, width of the internal iteration counter.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  run request; sampled only in IDLE.
- b  input  1  data path status y[s].
- y_inc  input  1  data path status, high when s==2.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- y_select_next  output  2  y next-value select: 0=y, 1=y+1, 2=y+s, 3=y-s.
- s_step  output  2  s increment/decrement amount.
- y_en  output  1  y register write enable.
- s_en  output  1  s register write enable.
- y_store_x  output  1  selects x into y.
- s_add  output  1  1: s_base+s_step, 0: s_base-s_step.
- s_zero  output  1  forces s_base to 0.

Behaviour:
- Interface:
  - One clock; reset is synchronous and active-high: clk and rst.
  - rst sampled high at a posedge forces IDLE and clears the iteration counter, overriding everything (including mid-run).
- Outputs:
  - Moore outputs, decoded from state only.
  - The data path's status inputs are used only for next-state and STEP decoding; they never create a combinational path to done/busy.
- Default output values:
  - All enables/selects 0, y_select_next=0, s_step=0.
  - These defaults are the values in IDLE and therefore after reset.
  - done=0, busy=0 after reset.
- States: IDLE, LOAD, SCAN, ADD, STEP, DONE.
- IDLE:
  - Outputs at defaults.
  - start=1 -> LOAD; otherwise stay.
- LOAD:
  - y_store_x=1, y_en=1, s_en=1, s_zero=1, s_add=1, s_step=0 (y<=x, s<=0).
  - Iteration counter <= 0.
  - -> SCAN.
- SCAN:
  - No enables.
  - b=1 -> ADD; b=0 -> STEP.
- ADD:
  - y_select_next=2, y_en=1 (y<=y+s).
  - -> STEP.
- STEP s update:
  - s_en=1, s_add=1, s_step=1 (s<=s+1, 3-bit wrap 7->0).
- STEP y update:
  - If y_inc=1: y_select_next=1, y_en=1 (y<=y+1, same cycle as the s update).
  - Otherwise y_en=0.
  - This is the only state with a status-dependent output.
- STEP exit:
  - If counter==N_STEPS-1 -> DONE.
  - Else counter+1 -> SCAN.
- DONE:
  - done=1, busy=1, no enables; y/s hold the result.
  - -> IDLE unconditionally.
- Handshake:
  - start outside IDLE is ignored (not queued).
  - start held high through DONE causes a new run beginning the cycle after the return to IDLE.
- Arithmetic:
  - y wraps modulo 256 and s modulo 8 in the data path.
  - The controller imposes no saturation.
- Latency:
  - The IDLE->DONE transition occurs 2 + 2*N_STEPS + (ADD visits) posedges after the posedge that samples start.
  - done is high in the cycle following that transition.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 -> state IDLE, busy=0, done=0, all control outputs 0; the first run starts only after rst drops.
- x=0x05, N_STEPS=8, start pulse -> 3 ADD visits, y_inc step at s=2; final y=0x0B, s=0; done one cycle high 21 edges after start sampled; busy high throughout.
- x=0x00 -> no ADD visits, single y+1 at s=2; final y=0x01, s=0; done 18 edges after start.
- STEP with y_inc=1 and ADD in the same iteration (x=0x04 at s=2) -> ADD asserts y_select_next=2; STEP asserts y_select_next=1, y_en=1, s_en=1 in the same cycle.
- start pulsed during SCAN/ADD/STEP -> ignored, result unchanged; start held high continuously -> back-to-back runs with exactly one IDLE cycle between done and the next LOAD.
- rst asserted in ADD mid-run -> next cycle IDLE, all outputs 0, no done pulse; a new start yields a correct full run.

Source files
------------

// File: rtl/scan_control_unit_if.sv
// Control/status bundle between the scan controller, the y/s data path and
// the top-level start/done handshake.
interface scan_control_unit_if;
   logic       start;
   logic       b;
   logic       y_inc;
   logic       busy;
   logic       done;
   logic [1:0] y_select_next;
   logic [1:0] s_step;
   logic       y_en;
   logic       s_en;
   logic       y_store_x;
   logic       s_add;
   logic       s_zero;

   // Controller side.
   modport master (
      input  start, b, y_inc,
      output busy, done, y_select_next, s_step,
             y_en, s_en, y_store_x, s_add, s_zero
   );

   // Data path / handshake side.
   modport slave (
      output start, b, y_inc,
      input  busy, done, y_select_next, s_step,
             y_en, s_en, y_store_x, s_add, s_zero
   );
endinterface

// File: rtl/scan_control_unit.sv
// Bit-scan accumulate controller: sequences the y/s data path through
// LOAD, N_STEPS scan iterations and a one-cycle DONE pulse per start.
module scan_control_unit #(
   parameter int N_STEPS = 8,
   parameter int CNT_W   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   scan_control_unit_if.master   ctl
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      SCAN = 3'd2,
      ADD  = 3'd3,
      STEP = 3'd4,
      DONE = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_STEPS - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      cnt_next          = cnt_reg;
      ctl.busy          = 1'b1;
      ctl.done          = 1'b0;
      ctl.y_select_next = 2'd0;
      ctl.s_step        = 2'd0;
      ctl.y_en          = 1'b0;
      ctl.s_en          = 1'b0;
      ctl.y_store_x     = 1'b0;
      ctl.s_add         = 1'b0;
      ctl.s_zero        = 1'b0;

      case (state_reg)
         IDLE: begin
            ctl.busy = 1'b0;
            if (ctl.start) state_next = LOAD;
         end
         LOAD: begin
            ctl.y_store_x = 1'b1;
            ctl.y_en      = 1'b1;
            ctl.s_en      = 1'b1;
            ctl.s_zero    = 1'b1;
            ctl.s_add     = 1'b1;
            cnt_next      = '0;
            state_next    = SCAN;
         end
         SCAN: begin
            state_next = ctl.b ? ADD : STEP;
         end
         ADD: begin
            ctl.y_select_next = 2'd2;
            ctl.y_en          = 1'b1;
            state_next        = STEP;
         end
         STEP: begin
            ctl.s_en   = 1'b1;
            ctl.s_add  = 1'b1;
            ctl.s_step = 2'd1;
            // The y+1 correction lands in the same cycle as the s advance.
            if (ctl.y_inc) begin
               ctl.y_select_next = 2'd1;
               ctl.y_en          = 1'b1;
            end
            if (cnt_reg == LAST_ITER) begin
               state_next = DONE;
            end else begin
               cnt_next   = cnt_reg + CNT_W'(1);
               state_next = SCAN;
            end
         end
         DONE: begin
            ctl.done   = 1'b1;
            state_next = IDLE;
         end
         default: begin
            ctl.busy   = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_scan_control_unit.sv
// Bench for scan_control_unit: behavioural y/s data path around the DUT,
// expected results from an algorithmic model held in a scoreboard queue.
module tb_scan_control_unit;

   typedef struct {
      logic [7:0] y;
      logic [2:0] s;
      int         lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] x = 8'h00;
   logic [7:0] y_dp = 8'h00;
   logic [2:0] s_dp = 3'd0;
   int n_checks = 0;
   int n_err = 0;
   exp_t exp_q[$];

   scan_control_unit_if ctl_if ();

   scan_control_unit #(.N_STEPS(8), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .ctl (ctl_if.master)
   );

   always #5 clk = ~clk;

   // Behavioural data path driven by the controller outputs.
   logic [2:0] s_base;
   assign s_base       = ctl_if.s_zero ? 3'd0 : s_dp;
   assign ctl_if.b     = y_dp[s_dp];
   assign ctl_if.y_inc = (s_dp == 3'd2);

   always @(posedge clk) begin
      if (ctl_if.y_en) begin
         if (ctl_if.y_store_x) y_dp <= x;
         else case (ctl_if.y_select_next)
            2'd0: y_dp <= y_dp;
            2'd1: y_dp <= y_dp + 8'd1;
            2'd2: y_dp <= y_dp + {5'd0, s_dp};
            default: y_dp <= y_dp - {5'd0, s_dp};
         endcase
      end
      if (ctl_if.s_en)
         s_dp <= ctl_if.s_add ? s_base + {1'b0, ctl_if.s_step}
                              : s_base - {1'b0, ctl_if.s_step};
   end

   function automatic logic [10:0] ctl_vec();
      return {ctl_if.busy, ctl_if.done, ctl_if.y_select_next, ctl_if.s_step,
              ctl_if.y_en, ctl_if.s_en, ctl_if.y_store_x, ctl_if.s_add,
              ctl_if.s_zero};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Algorithmic reference; latency counts posedges with the start-sampling
   // edge as 1, through the edge after which done is seen high.
   function automatic exp_t model(input logic [7:0] xv);
      exp_t e;
      logic [7:0] y = xv;
      logic [2:0] s = 3'd0;
      int adds = 0;
      for (int i = 0; i < 8; i++) begin
         if (y[s]) begin
            y = y + {5'd0, s};
            adds++;
         end
         if (s == 3'd2) y = y + 8'd1;
         s = s + 3'd1;
      end
      e.y = y;
      e.s = s;
      e.lat = 2 + 2 * 8 + adds;
      return e;
   endfunction

   task automatic run(input logic [7:0] xv, input bit probe, input bit pulse, input bit hold);
      exp_t e;
      int lat;
      x = xv;
      exp_q.push_back(model(xv));
      ctl_if.start = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      if (!hold) ctl_if.start = 1'b0;
      chk("load_store_x", {31'd0, ctl_if.y_store_x}, 32'd1);
      while (ctl_if.done !== 1'b1 && lat < 100) begin
         chk("busy_run", {31'd0, ctl_if.busy}, 32'd1);
         if (pulse) ctl_if.start = (lat >= 2 && lat <= 4);
         if (probe && lat == 7) begin
            chk("add_ysel", {30'd0, ctl_if.y_select_next}, 32'd2);
            chk("add_yen", {31'd0, ctl_if.y_en}, 32'd1);
         end
         if (probe && lat == 8) begin
            chk("step_ysel", {30'd0, ctl_if.y_select_next}, 32'd1);
            chk("step_yen_sen", {30'd0, ctl_if.y_en, ctl_if.s_en}, 32'd3);
         end
         @(posedge clk); #1;
         lat++;
      end
      e = exp_q.pop_front();
      chk("done_seen", {31'd0, ctl_if.done}, 32'd1);
      chk("latency", lat, e.lat);
      chk("y_result", {24'd0, y_dp}, {24'd0, e.y});
      chk("s_result", {29'd0, s_dp}, {29'd0, e.s});
      chk("busy_done", {31'd0, ctl_if.busy}, 32'd1);
      $display("run x=%02h y=%02h s=%0d latency=%0d", xv, y_dp, s_dp, lat);
      @(posedge clk); #1;
      chk("done_pulse_1cyc", {31'd0, ctl_if.done}, 32'd0);
      chk("idle_after_done", {31'd0, ctl_if.busy}, 32'd0);
   endtask

   initial begin
      bit seen_done;
      ctl_if.start = 1'b1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {21'd0, ctl_vec()}, 32'd0);
      @(posedge clk); #1;
      chk("reset_hold_idle", {21'd0, ctl_vec()}, 32'd0);
      rst = 1'b0;

      run(8'h05, 1'b0, 1'b0, 1'b0);
      run(8'h00, 1'b0, 1'b0, 1'b0);
      run(8'h04, 1'b1, 1'b0, 1'b0);
      run(8'h05, 1'b0, 1'b1, 1'b0);
      chk("pulse_not_queued", {31'd0, ctl_if.busy}, 32'd0);

      // start held high: back-to-back runs
      run(8'hA7, 1'b0, 1'b0, 1'b1);
      run(8'hFF, 1'b0, 1'b0, 1'b0);

      // reset in ADD, mid-run
      x = 8'h05;
      ctl_if.start = 1'b1;
      @(posedge clk); #1;
      ctl_if.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("in_add_state", {30'd0, ctl_if.y_select_next}, 32'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrun_reset_outputs", {21'd0, ctl_vec()}, 32'd0);
      seen_done = 1'b0;
      repeat (25) begin
         @(posedge clk); #1;
         if (ctl_if.done === 1'b1) seen_done = 1'b1;
      end
      chk("no_done_after_reset", {31'd0, seen_done}, 32'd0);

      run(8'h80, 1'b0, 1'b0, 1'b0);
      run(8'h33, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
